// File: rtl/reg8_write_arbiter_if.sv
// Bus bundle between up to four register-write requesters and the shared register arbiter.
interface reg8_write_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      Q;
  logic [1:0]            owner;
  logic                  busy;
  logic                  locked;

  modport master (
    output req, lock, wdata,
    input  gnt, Q, owner, busy, locked
  );

  modport slave (
    input  req, lock, wdata,
    output gnt, Q, owner, busy, locked
  );
endinterface

// File: rtl/reg8_write_arbiter.sv
// Round-robin write arbiter for a shared register, with optional lock
// giving one requester exclusive back-to-back writes.
module reg8_write_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input logic                  clock,
  input logic                  rst_n,
  reg8_write_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_LOCK = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             locked_q, locked_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] scan_idx;

  // Round-robin pick: first requester at or after ptr, wrapping mod NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    scan_idx  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan_idx = IDX_W'((32'(ptr_q) + i) % NREQ);
      if (!win_found && bus.req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Next-state and commit logic.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    q_d     = q_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          sel_d   = win_idx;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        q_d     = bus.wdata[32'(sel_q)*WIDTH +: WIDTH];
        owner_d = sel_q;
        ptr_d   = (32'(sel_q) == NREQ - 1) ? '0 : sel_q + IDX_W'(1);
        state_d = bus.lock[sel_q] ? ST_LOCK : ST_IDLE;
      end
      ST_LOCK: begin
        if (bus.req[sel_q]) begin
          state_d = ST_LOAD;
        end else if (!bus.lock[sel_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the upcoming state, so they track state_q exactly.
  always_comb begin
    gnt_d = '0;
    if (state_d == ST_LOAD) begin
      gnt_d[sel_d] = 1'b1;
    end
    busy_d   = (state_d != ST_IDLE);
    locked_d = (state_d == ST_LOCK);
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      ptr_q    <= '0;
      owner_q  <= '0;
      q_q      <= '0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      q_q      <= q_d;
      gnt_q    <= gnt_d;
      busy_q   <= busy_d;
      locked_q <= locked_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.Q      = q_q;
  assign bus.owner  = owner_q;
  assign bus.busy   = busy_q;
  assign bus.locked = locked_q;

endmodule

// File: tb/tb_reg8_write_arbiter.sv
// Scoreboard bench for reg8_write_arbiter: stimulus pushes expected grants,
// a negedge monitor pops and checks gnt, then Q/owner one cycle later.
module tb_reg8_write_arbiter;

  typedef struct {
    int unsigned idx;
    logic [7:0]  data;
  } exp_t;

  logic clock;
  logic rst_n;

  reg8_write_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

  reg8_write_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   errors;
  int   checks;
  exp_t exp_q[$];
  exp_t pend;
  bit   pend_v;
  bit   mon_en;
  logic [3:0] last_gnt;
  int   grant_cnt [4];
  int   drop_after [4];
  int   exp_lk [8] = '{0, 1, 0, 1, 0, 1, 0, 0};
  int   exp_bz [8] = '{1, 1, 1, 1, 1, 1, 0, 1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input int unsigned i, input logic [7:0] d);
    exp_t e;
    e.idx  = i;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Requester model: drop req/lock on the edge ending the last wanted grant, else advance data.
  task automatic cyc();
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (last_gnt[i] === 1'b1) begin
        grant_cnt[i]++;
        if (grant_cnt[i] >= drop_after[i]) begin
          bus.req[i]  = 1'b0;
          bus.lock[i] = 1'b0;
        end else begin
          bus.wdata[i*8 +: 8] = bus.wdata[i*8 +: 8] + 8'd1;
        end
      end
    end
  endtask

  task automatic do_reset(input bit check);
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.lock = '0;
    cyc();
    cyc();
    @(negedge clock);
    if (check) begin
      chk("rst_q",      32'(bus.Q),      32'(0));
      chk("rst_gnt",    32'(bus.gnt),    32'(0));
      chk("rst_owner",  32'(bus.owner),  32'(0));
      chk("rst_busy",   32'(bus.busy),   32'(0));
      chk("rst_locked", 32'(bus.locked), 32'(0));
    end
    for (int i = 0; i < 4; i++) begin
      grant_cnt[i]  = 0;
      drop_after[i] = 1;
    end
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor.
  always @(negedge clock) begin
    last_gnt = bus.gnt;
    if (rst_n !== 1'b1) begin
      pend_v = 1'b0;
    end else if (mon_en) begin
      if (pend_v) begin
        chk("q_after_gnt",     32'(bus.Q),     32'(pend.data));
        chk("owner_after_gnt", 32'(bus.owner), 32'(pend.idx));
        pend_v = 1'b0;
      end
      if (bus.gnt != 4'b0000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_gnt", 32'(bus.gnt), 32'(0));
        end else begin
          pend = exp_q.pop_front();
          chk("gnt_onehot", 32'(bus.gnt), 32'(1) << pend.idx);
          pend_v = 1'b1;
        end
      end
    end
  end

  initial begin
    errors    = 0;
    checks    = 0;
    pend_v    = 1'b0;
    mon_en    = 1'b0;
    last_gnt  = '0;
    rst_n     = 1'b0;
    bus.req   = '0;
    bus.lock  = '0;
    bus.wdata = '0;

    do_reset(1'b1);

    // Random activity, then reset must restore everything.
    for (int k = 0; k < 6; k++) begin
      cyc();
      bus.req   = 4'($urandom_range(0, 15));
      bus.lock  = 4'($urandom_range(0, 15));
      bus.wdata = 32'($urandom);
    end
    cyc();
    cyc();
    do_reset(1'b1);
    mon_en = 1'b1;

    // Single write: gnt one cycle after req, Q one cycle after gnt.
    cyc();
    bus.wdata[23:16] = 8'hA5;
    bus.req[2]       = 1'b1;
    push(2, 8'hA5);
    @(negedge clock);
    chk("single_gnt_n",   32'(bus.gnt),  32'(0));
    cyc();
    @(negedge clock);
    chk("single_gnt_n1",  32'(bus.gnt),  32'(4'b0100));
    chk("single_busy_n1", 32'(bus.busy), 32'(1));
    cyc();
    @(negedge clock);
    chk("single_gnt_n2",   32'(bus.gnt),   32'(0));
    chk("single_q_n2",     32'(bus.Q),     32'(8'hA5));
    chk("single_owner_n2", 32'(bus.owner), 32'(2));
    chk("single_busy_n2",  32'(bus.busy),  32'(0));
    cyc();
    chk("single_drained", 32'(exp_q.size()), 32'(0));

    // Fairness from ptr=0: order 0,1,2,3.
    do_reset(1'b0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      bus.wdata[i*8 +: 8] = 8'(8'h10 + i);
      push(i, 8'(8'h10 + i));
    end
    bus.req = 4'b1111;
    repeat (10) cyc();
    chk("fair_drained", 32'(exp_q.size()), 32'(0));
    chk("fair_q_last",  32'(bus.Q),        32'(8'h13));

    // Pointer wrapped to 0: with req 0 and 3 both up, 0 goes first.
    bus.wdata[7:0]   = 8'h40;
    bus.wdata[31:24] = 8'h43;
    bus.req          = 4'b1001;
    push(0, 8'h40);
    push(3, 8'h43);
    repeat (6) cyc();
    chk("wrap_drained", 32'(exp_q.size()), 32'(0));

    // Lock: three writes by requester 1 while requester 3 waits.
    bus.wdata[15:8]  = 8'h21;
    bus.wdata[31:24] = 8'h33;
    drop_after[1]    = 3;
    grant_cnt[1]     = 0;
    grant_cnt[3]     = 0;
    bus.lock         = 4'b0010;
    bus.req          = 4'b1010;
    push(1, 8'h21);
    push(1, 8'h22);
    push(1, 8'h23);
    push(3, 8'h33);
    for (int k = 0; k < 8; k++) begin
      cyc();
      @(negedge clock);
      chk($sformatf("lock_locked_c%0d", k + 1), 32'(bus.locked), 32'(exp_lk[k]));
      chk($sformatf("lock_busy_c%0d", k + 1),   32'(bus.busy),   32'(exp_bz[k]));
    end
    repeat (3) cyc();
    chk("lock_drained", 32'(exp_q.size()), 32'(0));
    chk("lock_q_last",  32'(bus.Q),        32'(8'h33));

    // Reset landing on the edge that closes a LOAD: no commit.
    mon_en = 1'b0;
    cyc();
    bus.wdata[7:0] = 8'h3C;
    bus.req[0]     = 1'b1;
    cyc();
    @(negedge clock);
    chk("midload_gnt", 32'(bus.gnt), 32'(4'b0001));
    rst_n   = 1'b0;
    bus.req = '0;
    cyc();
    @(negedge clock);
    chk("midload_q",      32'(bus.Q),      32'(0));
    chk("midload_owner",  32'(bus.owner),  32'(0));
    chk("midload_busy",   32'(bus.busy),   32'(0));
    chk("midload_gnt_after", 32'(bus.gnt), 32'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      grant_cnt[i]  = 0;
      drop_after[i] = 1;
    end

    // Idle stability after a write.
    mon_en = 1'b1;
    cyc();
    bus.wdata[23:16] = 8'h5A;
    bus.req[2]       = 1'b1;
    push(2, 8'h5A);
    repeat (4) cyc();
    for (int k = 0; k < 20; k++) begin
      cyc();
      @(negedge clock);
      chk("idle_q",    32'(bus.Q),    32'(8'h5A));
      chk("idle_gnt",  32'(bus.gnt),  32'(0));
      chk("idle_busy", 32'(bus.busy), 32'(0));
    end
    chk("idle_drained", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
